// File: rtl/uart_pkg.sv
// Shared UART types, default VIP configuration and helper functions.
// Defaults come from the SYS_FREQ, BAUD_RATE and DATA_SIZE macros, which fall back to the VIP configuration.
`ifndef SYS_FREQ
`define SYS_FREQ 1_600_000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 100_000
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

package uart_pkg;

  localparam int unsigned DEF_SYS_FREQ  = `SYS_FREQ;
  localparam int unsigned DEF_BAUD_RATE = `BAUD_RATE;
  localparam int unsigned DEF_DATA_SIZE = `DATA_SIZE;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned sys_freq,
                                               input int unsigned baud);
    return sys_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Load/decrement bit-timing counter; sample is high while the count sits at zero.
// Shared between the UART receiver and transmitter.
module uart_baud_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             sample
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Holds at zero once expired so an idle owner sees a steady strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample = (cnt_q == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, frame deserialiser and req/ack word handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned SYS_FREQ  = DEF_SYS_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 recv_req,
  input  logic                 recv_ack,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(SYS_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_SIZE - 1);

  rx_state_t            state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 armed_q, armed_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                 recv_req_q, recv_req_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 cnt_load;
  logic [CNT_W-1:0]     cnt_val;
  logic                 sample;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  uart_baud_cnt #(.WIDTH(CNT_W)) u_baud_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .sample   (sample)
  );

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    recv_req_d  = recv_req_q && !recv_ack;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    cnt_load    = 1'b0;
    cnt_val     = FULL_LOAD;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s_q) begin
          state_d  = START;
          cnt_load = 1'b1;
          cnt_val  = HALF_LOAD;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            cnt_load  = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_load           = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_bit_d = rx_s_q;
          cnt_load  = 1'b1;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          // A low stop bit may be a break, so demand a high line before the next start.
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift_q) ^ par_bit_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (!recv_req_q || recv_ack) begin
            dout_d     = shift_q;
            recv_req_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      armed_q     <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      recv_req_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      armed_q     <= armed_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      recv_req_q  <= recv_req_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign recv_req  = recv_req_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, 8 data bits.
// Expected words go into a queue as frames are driven and are popped when recv_req rises.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 170;
`else
  localparam int LAT = 154;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       recv_ack = 1'b0;
  logic [7:0] dout;
  logic       recv_req;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  logic [7:0] exp_q[$];

  // Event counters maintained only by the monitor below
  int   req_rises = 0;
  int   ferr_pulses = 0;
  int   ferr_cycles = 0;
  int   ferr_last_cyc = 0;
  int   perr_pulses = 0;
  int   perr_last_cyc = 0;
  logic req_prev = 1'b0;
  logic ferr_prev = 1'b0;

  uart_rx #(
    .SYS_FREQ  (1_600_000),
    .BAUD_RATE (100_000),
    .DATA_SIZE (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .dout      (dout),
    .recv_req  (recv_req),
    .recv_ack  (recv_ack),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (recv_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    if (frame_err === 1'b1) begin
      ferr_cycles++;
      ferr_last_cyc = cyc;
      if (ferr_prev !== 1'b1) ferr_pulses++;
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) begin
      perr_pulses++;
      perr_last_cyc = cyc;
    end
`endif
    req_prev  = recv_req;
    ferr_prev = frame_err;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one frame; the start bit goes low #1 after a rising edge.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit,
                            input bit bad_par, input bit push);
    logic [10:0] bits;
    int n;
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(data);
    last_start = cyc;
    bits = '0;
    bits[8:1] = data;
    n = 9;
`ifdef UART_RX_PARITY_EN
    bits[9] = (^data) ^ bad_par;
    n = 10;
`else
    if (bad_par) n = 9;
`endif
    bits[n] = stop_bit;
    for (int i = 0; i <= n; i++) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      rx = bits[i];
      repeat (CPB - 1) @(posedge clk);
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 recv_ack = 1'b1;
    @(posedge clk);
    #1 recv_ack = 1'b0;
  endtask

  task automatic wait_req(input int bound, output bit seen, output int at);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (recv_req === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got %h want 00", dout); end
    checks++;
    if (recv_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", recv_req); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got %b want 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic test_basic();
    int f0;
    bit seen;
    int at;
    logic [7:0] exp;
    f0 = ferr_pulses;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL basic_req_timeout got 0 want 1"); end
        checks++;
        if (at !== last_start + 1 + LAT) begin
          errors++; $display("[TB] FAIL basic_latency got %0d want %0d", at - last_start - 1, LAT);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL basic_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL basic_dout got %h want %h", dout, exp); end
        end
        repeat (2) @(posedge clk);
        #1 recv_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (recv_req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req_hold got %b want 1", recv_req); end
        @(posedge clk);
        #1 recv_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (recv_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_req_clear got %b want 0", recv_req); end
      end
    join
    checks++;
    if (ferr_pulses !== f0) begin errors++; $display("[TB] FAIL basic_ferr got %0d want %0d", ferr_pulses, f0); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL basic_overrun got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [2];
    logic [7:0] exp;
    bit seen;
    int at;
    want[0] = 8'h00;
    want[1] = 8'hFF;
    fork
      begin
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
        wait_req(LAT + 40, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL b2b_req%0d_timeout got 0 want 1", k); end
        checks++;
        if (at !== last_start + 1 + LAT) begin
          errors++; $display("[TB] FAIL b2b_latency%0d got %0d want %0d", k, at - last_start - 1, LAT);
        end
        checks++;
        if (dout !== want[k]) begin errors++; $display("[TB] FAIL b2b_dout%0d got %h want %h", k, dout, want[k]); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_scoreboard%0d got word %h want none queued", k, dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL b2b_sb%0d got %h want %h", k, dout, exp); end
        end
        pulse_ack();
      end
    join
    @(negedge clk);
    checks++;
    if (recv_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_req_final got %b want 0", recv_req); end
  endtask

  task automatic test_glitch();
    int r0;
    bit seen;
    int at;
    logic [7:0] exp;
    r0 = req_rises;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (req_rises !== r0 || recv_req !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_no_req got %0d rises want 0", req_rises - r0);
    end
    fork
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL glitch_req_timeout got 0 want 1"); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL glitch_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL glitch_dout got %h want %h", dout, exp); end
        end
        pulse_ack();
      end
    join
  endtask

  task automatic test_frame_err();
    int f0, c0, r0, s0;
    bit seen;
    int at;
    logic [7:0] exp;
    f0 = ferr_pulses;
    c0 = ferr_cycles;
    r0 = req_rises;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    s0 = last_start;
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    @(negedge clk);
    checks++;
    if (ferr_pulses !== f0 + 1) begin errors++; $display("[TB] FAIL ferr_pulses got %0d want %0d", ferr_pulses - f0, 1); end
    checks++;
    if (ferr_cycles !== c0 + 1) begin errors++; $display("[TB] FAIL ferr_width got %0d want 1", ferr_cycles - c0); end
    checks++;
    if (ferr_last_cyc !== s0 + 1 + LAT) begin
      errors++; $display("[TB] FAIL ferr_edge got %0d want %0d", ferr_last_cyc - s0 - 1, LAT);
    end
    checks++;
    if (req_rises !== r0) begin errors++; $display("[TB] FAIL ferr_no_req got %0d rises want 0", req_rises - r0); end
    repeat (32) @(posedge clk);
    fork
      send_frame(8'h81, 1'b1, 1'b0, 1'b1);
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL ferr_next_timeout got 0 want 1"); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL ferr_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL ferr_next_dout got %h want %h", dout, exp); end
        end
        pulse_ack();
      end
    join
  endtask

  task automatic test_overrun();
    int r0;
    bit seen, ov;
    int at, ov_at;
    logic [7:0] exp;
    r0 = req_rises;
    fork
      begin
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
      end
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL ovr_req_timeout got 0 want 1"); end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL ovr_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL ovr_dout got %h want %h", dout, exp); end
        end
        ov = 1'b0;
        ov_at = 0;
        for (int i = 0; i < CPB * 12 && !ov; i++) begin
          @(negedge clk);
          if (overrun === 1'b1) begin
            ov = 1'b1;
            ov_at = cyc;
          end
        end
        checks++;
        if (!ov) begin errors++; $display("[TB] FAIL ovr_flag_timeout got 0 want 1"); end
        checks++;
        if (ov_at !== last_start + 1 + LAT) begin
          errors++; $display("[TB] FAIL ovr_edge got %0d want %0d", ov_at - last_start - 1, LAT);
        end
        checks++;
        if (dout !== 8'h11 || recv_req !== 1'b1) begin
          errors++; $display("[TB] FAIL ovr_hold got dout=%h req=%b want dout=11 req=1", dout, recv_req);
        end
      end
    join
    pulse_ack();
    @(negedge clk);
    checks++;
    if (recv_req !== 1'b0) begin errors++; $display("[TB] FAIL ovr_ack_clear got %b want 0", recv_req); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky got %b want 1", overrun); end
    checks++;
    if (req_rises !== r0 + 1) begin errors++; $display("[TB] FAIL ovr_rises got %0d want 1", req_rises - r0); end
  endtask

  task automatic test_mid_reset();
    int r0;
    bit seen;
    int at;
    logic [7:0] exp;
    r0 = 0;
    fork
      send_frame(8'h77, 1'b1, 1'b0, 1'b0);
      begin
        @(posedge clk);
        repeat (60) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dout !== 8'h00 || recv_req !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("[TB] FAIL mreset_outputs got dout=%h req=%b ferr=%b ovr=%b want all 0",
                   dout, recv_req, frame_err, overrun);
        end
        r0 = req_rises;
      end
    join
    checks++;
    if (req_rises !== r0) begin errors++; $display("[TB] FAIL mreset_no_req got %0d rises want 0", req_rises - r0); end
    // Resynchronising on the remaining data bits can yield one junk word; drain it.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (recv_req === 1'b1) pulse_ack();
    end
    fork
      send_frame(8'h99, 1'b1, 1'b0, 1'b1);
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL mreset_next_timeout got 0 want 1"); end
        checks++;
        if (at !== last_start + 1 + LAT) begin
          errors++; $display("[TB] FAIL mreset_latency got %0d want %0d", at - last_start - 1, LAT);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL mreset_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL mreset_dout got %h want %h", dout, exp); end
        end
        pulse_ack();
      end
    join
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0, r0, s0;
    bit seen;
    int at;
    logic [7:0] exp;
    p0 = perr_pulses;
    r0 = req_rises;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    s0 = last_start;
    repeat (8) @(negedge clk);
    checks++;
    if (perr_pulses !== p0 + 1) begin errors++; $display("[TB] FAIL par_pulse got %0d want 1", perr_pulses - p0); end
    checks++;
    if (perr_last_cyc !== s0 + 1 + LAT) begin
      errors++; $display("[TB] FAIL par_edge got %0d want %0d", perr_last_cyc - s0 - 1, LAT);
    end
    checks++;
    if (req_rises !== r0) begin errors++; $display("[TB] FAIL par_no_req got %0d rises want 0", req_rises - r0); end
    fork
      send_frame(8'h07, 1'b1, 1'b0, 1'b1);
      begin
        wait_req(LAT + 20, seen, at);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL par_req_timeout got 0 want 1"); end
        checks++;
        if (at !== last_start + 1 + LAT) begin
          errors++; $display("[TB] FAIL par_latency got %0d want %0d", at - last_start - 1, LAT);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL par_scoreboard got word %h want none queued", dout);
        end else begin
          exp = exp_q.pop_front();
          if (dout !== exp) begin errors++; $display("[TB] FAIL par_dout got %h want %h", dout, exp); end
        end
        pulse_ack();
      end
    join
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_mid_reset();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drain got %0d words left want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver of the UART VIP DUT pair: samples the asynchronous `rx` line and deserialises one frame (start bit, DATA_SIZE data bits LSB-first, optional parity, one stop bit).
- Presents each received word on `dout` with a `recv_req`/`recv_ack` handshake to the consumer.
- Sits directly downstream of the serial line driven by the transmitter / driver agent.

Parameters:
- SYS_FREQ, `SYS_FREQ: system clock frequency in Hz.
- BAUD_RATE, `BAUD_RATE: line rate in bits per second.
- DATA_SIZE, `DATA_SIZE: data bits per frame (5..9).
- Derived constants, not overridable:
  - CLKS_PER_BIT = SYS_FREQ/BAUD_RATE (integer division).
  - HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- dout  output  DATA_SIZE  received word, valid while recv_req=1.
- recv_req  output  1  word-available request.
- recv_ack  input  1  consumer acknowledge.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  sticky: a frame completed while recv_req=1.

Behaviour:
- Reset: a synchronous low on reset_n at any clk edge, including mid-frame, sets:
  - state=IDLE, counters=0
  - dout=0, recv_req=0, frame_err=0, overrun=0
  - sync flops=1
  - armed=0
- Synchroniser: two flops, rx to rx_meta to rx_s. Reset value 1. Only rx_s is used downstream.
- Bit counter: loads a value, decrements every cycle, and triggers a "sample" at the edge where it equals 0.
- State IDLE:
  - armed is set when rx_s=1.
  - If armed and rx_s=0, go to START with cnt=HALF_BIT-1.
- State START, at sample:
  - rx_s=1: glitch; go to IDLE (armed stays 1).
  - rx_s=0: go to DATA with cnt=CLKS_PER_BIT-1 and bit_idx=0.
- State DATA:
  - At each sample, shift_reg[bit_idx]=rx_s and reload cnt.
  - After bit DATA_SIZE-1, go to STOP (or PARITY with the macro).
- State STOP, at sample: always go to IDLE.
  - rx_s=1 and recv_req=0: dout<=shift_reg, recv_req<=1 at that same edge.
  - rx_s=1 and recv_req=1: overrun<=1; dout is unchanged; the new word is dropped.
  - rx_s=0: frame_err pulses 1 cycle, word discarded, armed<=0. A new start requires the line to return high first (break handling).
- Latency:
  - Edge 0 is the first edge at which rx is sampled low.
  - recv_req rises at edge 2+HALF_BIT+(DATA_SIZE+1)*CLKS_PER_BIT.
  - Example: CLKS_PER_BIT=16, DATA_SIZE=8 gives edge 154.
- Handshake:
  - dout is stable while recv_req=1.
  - recv_ack sampled 1 while recv_req=1 clears recv_req at the next edge.
  - recv_ack while recv_req=0 is ignored.
  - Ack and a stop-bit sample in the same cycle: the ack clears the old request, and the new word loads with recv_req staying 1. No overrun is raised.
- overrun clears only on reset.
- Reception continues regardless of recv_req; the handshake never stalls the line.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA; one bit is sampled there.
  - Even parity over data bits plus the parity bit is required.
  - Mismatch gives port parity_err (output, 1) as a one-cycle pulse at the stop-bit sample edge, and the word is discarded (recv_req not raised).
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err port; the frame is exactly 1+DATA_SIZE+1 bits.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic[2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}
  - function clks_per_bit(sys_freq, baud)
  - localparam defaults for the VIP configuration
- One sub-module, uart_baud_cnt: a load/decrement counter with a sample-strobe output, reusable by the transmitter.
- The synchroniser stays inline.

Test Plan (SYS_FREQ=1_600_000, BAUD_RATE=100_000 giving CLKS_PER_BIT=16; DATA_SIZE=8; macro undefined unless noted):
- Frame 0xA5, ack 3 cycles after recv_req:
  - dout=0xA5 and recv_req=1 at edge 154.
  - recv_req=0 one edge after ack.
  - frame_err=0 and overrun=0 throughout.
- Back-to-back 0x00 then 0xFF with no idle gap, ack each immediately: two requests, dout=0x00 then 0xFF.
- 4-cycle low glitch on rx: returns to IDLE, recv_req stays 0; a following frame 0x3C is received correctly.
- Frame 0x55 with stop bit 0, then line held low 40 cycles, then frame 0x81:
  - frame_err one-cycle pulse, no recv_req for 0x55.
  - 0x81 is received.
- Frames 0x11 and 0x22 with no ack: dout stays 0x11, overrun=1 after the second stop bit; ack then clears recv_req with overrun still 1.
- Mid-frame reset_n=0 for 1 cycle at edge 60 of frame 0x77: all outputs 0, no recv_req; the next frame 0x99 is received correctly.
- With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (odd total): parity_err pulse, no recv_req. With parity bit 1: dout=0x07 at edge 170.
